// File: rtl/fetch_pkg.sv
// Shared defaults and the prefetch-buffer entry layout for the instruction fetch stage.
package fetch_pkg;

  localparam int INSTR_W_DEF  = 18;
  localparam int ADDR_W_DEF   = 10;
  localparam int RESET_PC_DEF = 0;

  typedef struct packed {
    logic [INSTR_W_DEF-1:0] instr;
    logic [ADDR_W_DEF-1:0]  pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// ROM, redirect and control-unit handshake signals of the fetch stage.
interface fetch_unit_if
  import fetch_pkg::*;
#(
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF
);
  logic               FETCH_ENABLE;
  logic [ADDR_W-1:0]  ROM_ADDR;
  logic [INSTR_W-1:0] ROM_DATA;
  logic               JUMP_SIGNAL;
  logic [ADDR_W-1:0]  JUMP_TARGET;
  logic [INSTR_W-1:0] INSTR;
  logic [ADDR_W-1:0]  INSTR_PC;
  logic               INSTR_VALID;
  logic               INSTR_READY;

  modport master (
    input  FETCH_ENABLE, ROM_DATA, JUMP_SIGNAL, JUMP_TARGET, INSTR_READY,
    output ROM_ADDR, INSTR, INSTR_PC, INSTR_VALID
  );

  modport slave (
    output FETCH_ENABLE, ROM_DATA, JUMP_SIGNAL, JUMP_TARGET, INSTR_READY,
    input  ROM_ADDR, INSTR, INSTR_PC, INSTR_VALID
  );
endinterface

// File: rtl/fetch_unit_instr_fifo.sv
// Small synchronous FIFO holding fetched {instr, pc} entries; flush beats push and pop.
module instr_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  entry_t                 din,
  output entry_t                 head,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues ROM reads under a credit limit,
// buffers returned words and redirects on jumps.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int INSTR_W  = INSTR_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DEPTH    = 2,
  parameter int RESET_PC = RESET_PC_DEF
) (
  input logic          CPU_CLOCK,
  input logic          CLEAR,
  fetch_unit_if.master bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } entry_t;

  logic [ADDR_W-1:0] pc_p0;
  logic [ADDR_W-1:0] tag_p1;
  logic              vld_p1;
  entry_t            din_p1;
  entry_t            head_p2;
  entry_t            last_p2;
  entry_t            out_p2;
  logic              empty_p2;
  logic [CW-1:0]     count_p2;
  logic [CW:0]       occ;
  logic              pop;
  logic              push;
  logic              issue;

  assign pop   = bus.INSTR_VALID & bus.INSTR_READY;
  // Occupancy after this edge's pop, counting the read already in flight.
  assign occ   = (CW+1)'(count_p2) + (CW+1)'(vld_p1) - (CW+1)'(pop);
  assign issue = bus.FETCH_ENABLE & ~bus.JUMP_SIGNAL & (occ < (CW+1)'(DEPTH));
  assign push  = vld_p1 & ~bus.JUMP_SIGNAL;

  // Issue stage: PC owns the ROM address
  always_ff @(posedge CPU_CLOCK) begin
    if (CLEAR) begin
      pc_p0  <= ADDR_W'(RESET_PC);
      vld_p1 <= 1'b0;
    end else if (bus.JUMP_SIGNAL) begin
      pc_p0  <= bus.JUMP_TARGET;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= issue;
      if (issue) pc_p0 <= pc_p0 + 1'b1;
    end
  end

  always_ff @(posedge CPU_CLOCK) begin
    if (issue) tag_p1 <= pc_p0;
  end

  // Capture stage: ROM word pairs with the address it was read from
  assign din_p1.instr = bus.ROM_DATA;
  assign din_p1.pc    = tag_p1;

  instr_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk   (CPU_CLOCK),
    .rst   (CLEAR),
    .push  (push),
    .pop   (pop),
    .flush (bus.JUMP_SIGNAL),
    .din   (din_p1),
    .head  (head_p2),
    .empty (empty_p2),
    .count (count_p2)
  );

  // Output stage: outputs keep the last presented entry while the buffer is empty
  always_ff @(posedge CPU_CLOCK) begin
    if (CLEAR)          last_p2 <= '0;
    else if (!empty_p2) last_p2 <= head_p2;
  end

  assign out_p2          = empty_p2 ? last_p2 : head_p2;
  assign bus.ROM_ADDR    = pc_p0;
  assign bus.INSTR       = out_p2.instr;
  assign bus.INSTR_PC    = out_p2.pc;
  assign bus.INSTR_VALID = ~empty_p2;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic against a queue-based model.
module tb_fetch_unit;
  localparam int AW    = 10;
  localparam int IW    = 18;
  localparam int DEPTH = 2;

  typedef struct {
    logic [IW-1:0] instr;
    logic [AW-1:0] pc;
  } ent_t;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  fetch_unit_if #(.INSTR_W(IW), .ADDR_W(AW)) bus  ();
  fetch_unit_if #(.INSTR_W(IW), .ADDR_W(AW)) bus2 ();

  fetch_unit #(.INSTR_W(IW), .ADDR_W(AW), .DEPTH(DEPTH), .RESET_PC(0)) dut (
    .CPU_CLOCK (clk),
    .CLEAR     (clr),
    .bus       (bus.master)
  );

  fetch_unit #(.INSTR_W(IW), .ADDR_W(AW), .DEPTH(DEPTH), .RESET_PC(1022)) dut_wrap (
    .CPU_CLOCK (clk),
    .CLEAR     (clr),
    .bus       (bus2.master)
  );

  function automatic logic [IW-1:0] rom_word(input logic [AW-1:0] a);
    return 18'h100 + {8'b0, a};
  endfunction

  always @(posedge clk) bus.ROM_DATA  <= rom_word(bus.ROM_ADDR);
  always @(posedge clk) bus2.ROM_DATA <= rom_word(bus2.ROM_ADDR);

  ent_t m_buf[$];
  int   m_fl[$];
  int   m_pc;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit   pop;
    bit   iss;
    ent_t e;
    if (clr) begin
      m_pc = 0;
      m_buf.delete();
      m_fl.delete();
    end else begin
      pop = (m_buf.size() > 0) && bus.INSTR_READY;
      if (bus.JUMP_SIGNAL) begin
        m_buf.delete();
        m_fl.delete();
        m_pc = int'(bus.JUMP_TARGET);
      end else begin
        iss = bus.FETCH_ENABLE && ((m_buf.size() + m_fl.size() - int'(pop)) < DEPTH);
        if (pop) void'(m_buf.pop_front());
        if (m_fl.size() > 0) begin
          e.pc    = AW'(m_fl[0]);
          e.instr = rom_word(e.pc);
          m_buf.push_back(e);
          m_fl.delete();
        end
        if (iss) begin
          m_fl.push_back(m_pc);
          m_pc = (m_pc + 1) % (1 << AW);
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check("rom_addr", 32'(bus.ROM_ADDR), 32'(m_pc));
    check("valid", 32'(bus.INSTR_VALID), 32'(m_buf.size() > 0));
    if (m_buf.size() > 0) begin
      check("instr", 32'(bus.INSTR), 32'(m_buf[0].instr));
      check("instr_pc", 32'(bus.INSTR_PC), 32'(m_buf[0].pc));
    end
  endtask

  initial begin
    int saved_pc;
    clr = 1'b1;
    bus.FETCH_ENABLE = 1'b0;
    bus.INSTR_READY  = 1'b0;
    bus.JUMP_SIGNAL  = 1'b0;
    bus.JUMP_TARGET  = '0;
    bus2.FETCH_ENABLE = 1'b1;
    bus2.INSTR_READY  = 1'b1;
    bus2.JUMP_SIGNAL  = 1'b0;
    bus2.JUMP_TARGET  = '0;
    step();
    step();
    check("rst_instr", 32'(bus.INSTR), 32'h0);
    check("rst_instr_pc", 32'(bus.INSTR_PC), 32'h0);
    check("rst_valid", 32'(bus.INSTR_VALID), 32'h0);
    check("rst_rom_addr", 32'(bus.ROM_ADDR), 32'h0);
    check("rst_wrap_rom_addr", 32'(bus2.ROM_ADDR), 32'd1022);

    // Streaming from reset, wrap instance in lockstep
    clr = 1'b0;
    bus.FETCH_ENABLE = 1'b1;
    bus.INSTR_READY  = 1'b1;
    step();
    check("lat_edge1_valid", 32'(bus.INSTR_VALID), 32'h0);
    step();
    check("first_valid", 32'(bus.INSTR_VALID), 32'h1);
    check("first_instr", 32'(bus.INSTR), 32'h100);
    check("wrap_pc0", 32'(bus2.INSTR_PC), 32'd1022);
    for (int i = 1; i <= 5; i++) begin
      step();
      check("stream_instr", 32'(bus.INSTR), 32'h100 + 32'(i));
      check("stream_pc", 32'(bus.INSTR_PC), 32'(i));
      if (i <= 3) check("wrap_pc", 32'(bus2.INSTR_PC), 32'((1022 + i) % 1024));
    end

    // CLEAR mid-stream, then backpressure after restart
    clr = 1'b1;
    step();
    check("clr_mid_valid", 32'(bus.INSTR_VALID), 32'h0);
    check("clr_mid_rom_addr", 32'(bus.ROM_ADDR), 32'h0);
    clr = 1'b0;
    step();
    step();
    check("restart_instr", 32'(bus.INSTR), 32'h100);
    bus.INSTR_READY = 1'b0;
    repeat (5) step();
    check("bp_rom_addr", 32'(bus.ROM_ADDR), 32'd2);
    check("bp_instr", 32'(bus.INSTR), 32'h100);
    check("bp_instr_pc", 32'(bus.INSTR_PC), 32'h0);
    bus.INSTR_READY = 1'b1;
    step();
    check("bp_rel1", 32'(bus.INSTR), 32'h101);
    step();
    check("bp_rel2", 32'(bus.INSTR), 32'h102);

    // Redirect while streaming
    repeat (3) step();
    bus.JUMP_SIGNAL = 1'b1;
    bus.JUMP_TARGET = 10'h3A0;
    step();
    check("jmp_valid_next", 32'(bus.INSTR_VALID), 32'h0);
    bus.JUMP_SIGNAL = 1'b0;
    step();
    check("jmp_valid_edge1", 32'(bus.INSTR_VALID), 32'h0);
    step();
    check("jmp_valid_edge2", 32'(bus.INSTR_VALID), 32'h1);
    check("jmp_target_pc", 32'(bus.INSTR_PC), 32'h3A0);
    check("jmp_target_instr", 32'(bus.INSTR), 32'h4A0);

    // Redirect with a full buffer
    bus.INSTR_READY = 1'b0;
    step();
    step();
    bus.JUMP_SIGNAL = 1'b1;
    bus.JUMP_TARGET = 10'h155;
    step();
    check("jmp_full_valid", 32'(bus.INSTR_VALID), 32'h0);
    bus.JUMP_SIGNAL = 1'b0;
    bus.INSTR_READY = 1'b1;
    repeat (4) step();

    // FETCH_ENABLE dropped right after an issue
    saved_pc = m_pc;
    bus.FETCH_ENABLE = 1'b0;
    step();
    check("fe_inflight_valid", 32'(bus.INSTR_VALID), 32'h1);
    check("fe_inflight_pc", 32'(bus.INSTR_PC), 32'((saved_pc + 1023) % 1024));
    repeat (4) begin
      step();
      check("fe_rom_hold", 32'(bus.ROM_ADDR), 32'(saved_pc));
    end
    bus.FETCH_ENABLE = 1'b1;
    repeat (3) step();

    // Random traffic
    repeat (400) begin
      bus.FETCH_ENABLE = ($urandom_range(0, 3) != 0);
      bus.INSTR_READY  = ($urandom_range(0, 3) != 0);
      bus.JUMP_SIGNAL  = ($urandom_range(0, 7) == 0);
      bus.JUMP_TARGET  = AW'($urandom);
      clr              = ($urandom_range(0, 63) == 0);
      step();
    end
    clr = 1'b0;
    bus.JUMP_SIGNAL = 1'b0;
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
